// File: rtl/subtractor_16_bit_seq_pkg.sv
// Shared definitions for the sequential 16-bit subtractor: FSM encoding and datapath widths.
package sub_pkg;

    localparam int WIDTH = 16;
    localparam int SLICE = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2
    } state_t;

endpackage

// File: rtl/subtractor_8_bit.sv
// Combinational 8-bit subtract slice with borrow-in and borrow-out: {bo, d} = x - y - bi.
module subtractor_8_bit
    import sub_pkg::*;
(
    output logic [SLICE-1:0] d,
    output logic             bo,
    input  logic             bi,
    input  logic [SLICE-1:0] x,
    input  logic [SLICE-1:0] y
);

    logic [SLICE:0] diff_ext;

    // Nine-bit subtraction; the top bit wraps to 1 exactly when a borrow is needed.
    assign diff_ext = {1'b0, x} - {1'b0, y} - {{SLICE{1'b0}}, bi};
    assign d        = diff_ext[SLICE-1:0];
    assign bo       = diff_ext[SLICE];

endmodule

// File: rtl/subtractor_16_bit_seq.sv
// Sequential 16-bit subtractor: d = a - b - bin over two cycles through one shared 8-bit slice.
//
//   state | meaning
//   IDLE  | ready=1, waiting for start; operands latched on accepted start
//   LOW   | low byte subtracted, partial result and borrow registered
//   HIGH  | high byte subtracted, d/flags updated, done pulsed
module subtractor_16_bit_seq
    import sub_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             ready,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             ovf,
    output logic             zero,
    output logic             done
);

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             bin_q;
    logic             brw;
    logic [SLICE-1:0] d_lo;

    logic [SLICE-1:0] slice_x;
    logic [SLICE-1:0] slice_y;
    logic             slice_bi;
    logic [SLICE-1:0] slice_d;
    logic             slice_bo;
    logic [WIDTH-1:0] d_full;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        slice_x   = a_q[SLICE-1:0];
        slice_y   = b_q[SLICE-1:0];
        slice_bi  = bin_q;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    state_nxt = LOW;
                end
            end
            LOW: begin
                state_nxt = HIGH;
            end
            HIGH: begin
                slice_x   = a_q[WIDTH-1:SLICE];
                slice_y   = b_q[WIDTH-1:SLICE];
                slice_bi  = brw;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    subtractor_8_bit u_slice (
        .d  (slice_d),
        .bo (slice_bo),
        .bi (slice_bi),
        .x  (slice_x),
        .y  (slice_y)
    );

    assign d_full = {slice_d, d_lo};

    // Operands only load from IDLE, so a start while busy cannot disturb the op in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            bin_q <= 1'b0;
        end else if (state == IDLE && start) begin
            a_q   <= a;
            b_q   <= b;
            bin_q <= bin;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            d_lo <= '0;
            brw  <= 1'b0;
        end else if (state == LOW) begin
            d_lo <= slice_d;
            brw  <= slice_bo;
        end
    end

    // Visible result registers update together on the HIGH->IDLE edge only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            d    <= '0;
            bout <= 1'b0;
            ovf  <= 1'b0;
            zero <= 1'b0;
            done <= 1'b0;
        end else if (state == HIGH) begin
            d    <= d_full;
            bout <= slice_bo;
            ovf  <= (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (slice_d[SLICE-1] ^ a_q[WIDTH-1]);
            zero <= (d_full == '0);
            done <= 1'b1;
        end else begin
            done <= 1'b0;
        end
    end

endmodule

// File: tb/tb_subtractor_16_bit_seq.sv
// Self-checking bench for subtractor_16_bit_seq: vector table, scoreboard queue, busy/reset corner cases.
module tb_subtractor_16_bit_seq;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        bin;
        logic [15:0] d;
        logic        bout;
        logic        ovf;
        logic        zero;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic        ready;
    logic [15:0] d;
    logic        bout;
    logic        ovf;
    logic        zero;
    logic        done;

    int n_cmp = 0;
    int n_err = 0;

    vec_t vecs [10];
    vec_t sb_q [$];

    subtractor_16_bit_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .ready (ready),
        .d     (d),
        .bout  (bout),
        .ovf   (ovf),
        .zero  (zero),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t model(input logic [15:0] x, input logic [15:0] y, input logic ci);
        vec_t v;
        logic [16:0] r;
        r      = {1'b0, x} - {1'b0, y} - {16'b0, ci};
        v.a    = x;
        v.b    = y;
        v.bin  = ci;
        v.d    = r[15:0];
        v.bout = r[16];
        v.ovf  = (x[15] != y[15]) && (r[15] != x[15]);
        v.zero = (r[15:0] == 16'h0000);
        return v;
    endfunction

    task automatic compare_result(input string tag);
        vec_t e;
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
            return;
        end
        e = sb_q.pop_front();
        chk({tag, "_d"},    {16'b0, d}, {16'b0, e.d});
        chk({tag, "_bout"}, {31'b0, bout}, {31'b0, e.bout});
        chk({tag, "_ovf"},  {31'b0, ovf},  {31'b0, e.ovf});
        chk({tag, "_zero"}, {31'b0, zero}, {31'b0, e.zero});
    endtask

    // Drive one start, scramble inputs after acceptance, wait (bounded) for done.
    task automatic do_op(input string tag, input vec_t v);
        int lat;
        @(negedge clk);
        chk({tag, "_ready"}, {31'b0, ready}, 32'd1);
        a     = v.a;
        b     = v.b;
        bin   = v.bin;
        start = 1'b1;
        sb_q.push_back(v);
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = 16'($urandom);
        b     = 16'($urandom);
        bin   = 1'($urandom);
        lat   = 0;
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
        end
        chk({tag, "_latency"}, lat, 32'd2);
        if (lat != 0) begin
            compare_result(tag);
            @(posedge clk);
            #1;
            chk({tag, "_done_drop"}, {31'b0, done}, 32'd0);
            chk({tag, "_d_held"}, {16'b0, d}, {16'b0, v.d});
        end else begin
            void'(sb_q.pop_front());
        end
    endtask

    initial begin
        vec_t e;
        vecs[0] = '{16'h1234, 16'h0034, 1'b0, 16'h1200, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{16'h0100, 16'h0001, 1'b0, 16'h00FF, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{16'h5555, 16'h5555, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{16'hFFFF, 16'h0000, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{16'h8000, 16'h7FFF, 1'b0, 16'h0001, 1'b0, 1'b1, 1'b0};
        vecs[9] = '{16'h00FF, 16'h00FF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};

        rst_n = 1'b0;
        start = 1'b0;
        a     = 16'h0;
        b     = 16'h0;
        bin   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {31'b0, ready}, 32'd1);
        chk("rst_d",     {16'b0, d},     32'd0);
        chk("rst_flags", {29'b0, bout, ovf, zero}, 32'd0);
        chk("rst_done",  {31'b0, done},  32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i]);
        end

        for (int i = 0; i < 20; i++) begin
            do_op($sformatf("rnd%0d", i), model(16'($urandom), 16'($urandom), 1'($urandom)));
        end

        // start held through LOW and HIGH with other operands must be ignored
        @(negedge clk);
        e     = model(16'h3000, 16'h0FFF, 1'b1);
        a     = e.a;
        b     = e.b;
        bin   = e.bin;
        start = 1'b1;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        chk("busy_low_ready", {31'b0, ready}, 32'd0);
        a   = 16'hDEAD;
        b   = 16'hBEEF;
        bin = 1'b0;
        @(posedge clk);
        #1;
        chk("busy_high_ready", {31'b0, ready}, 32'd0);
        chk("busy_high_nodone", {31'b0, done}, 32'd0);
        a = 16'h0F0F;
        b = 16'h00F0;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_done", {31'b0, done}, 32'd1);
        chk("busy_ready_with_done", {31'b0, ready}, 32'd1);
        compare_result("busy");
        do_op("after_busy", model(16'h0F0F, 16'h00F0, 1'b0));

        // reset asserted while in HIGH aborts the operation
        @(negedge clk);
        a     = 16'h4321;
        b     = 16'h0001;
        bin   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_done",  {31'b0, done},  32'd0);
        chk("abort_d",     {16'b0, d},     32'd0);
        chk("abort_flags", {29'b0, bout, ovf, zero}, 32'd0);
        chk("abort_ready", {31'b0, ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        do_op("after_abort", vecs[4]);

        chk("sb_drained", sb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
